// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the joystick ADC sequencer.
// Holds the FSM state encoding and the two LTC2308 config words.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONVST    = 3'd1,
        CONV_WAIT = 3'd2,
        SHIFT     = 3'd3,
        PUBLISH   = 3'd4
    } state_t;

    // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, O/S picks the channel
    localparam logic [5:0] CFG_CH0  = 6'b100010;
    localparam logic [5:0] CFG_CH1  = 6'b110010;
    localparam int         SAMPLE_W = 12;

    function automatic logic [5:0] cfgFor(input logic ch);
        return ch ? CFG_CH1 : CFG_CH0;
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SPI clock divider for the ADC sequencer: SCK_HALF clocks per half-period,
// strobes on each SCK edge and a done flag on the 12th falling edge.
module adc_sck_gen #(
    parameter int SCK_HALF = 4
) (
    input  logic clk_i,
    input  logic rstN_i,
    input  logic run_i,
    output logic sck_o,
    output logic riseStb_o,
    output logic fallStb_o,
    output logic done_o
);

    localparam logic [15:0] HALF_LAST = 16'(SCK_HALF - 1);

    logic [15:0] halfCnt_q;
    logic        sck_q;
    logic [3:0]  periods_q;
    logic        edgeStb;

    assign edgeStb   = run_i && (halfCnt_q == HALF_LAST);
    assign riseStb_o = edgeStb && !sck_q;
    assign fallStb_o = edgeStb && sck_q;
    assign done_o    = fallStb_o && (periods_q == 4'd11);
    assign sck_o     = sck_q;

    // Dropping run parks the divider so every frame starts with SCK low and a fresh count
    always_ff @(posedge clk_i) begin
        if (!rstN_i || !run_i) begin
            halfCnt_q <= '0;
            sck_q     <= 1'b0;
            periods_q <= '0;
        end else if (halfCnt_q == HALF_LAST) begin
            halfCnt_q <= '0;
            sck_q     <= ~sck_q;
            if (sck_q) begin
                periods_q <= periods_q + 4'd1;
            end
        end else begin
            halfCnt_q <= halfCnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/adc_joystick_seq.sv
// Alternating two-channel LTC2308 sequencer feeding the speed/direction controller.
// Optional feature: define ADC_SEQ_AVG_EN to publish 4-sample averages per channel.
module adc_joystick_seq
    import adc_seq_pkg::*;
#(
    parameter int SCK_HALF      = 4,
    parameter int CONVST_CYCLES = 2,
    parameter int CONV_CYCLES   = 80,
    parameter int GAP_CYCLES    = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_enable,
    output logic        o_adc_convst,
    output logic        o_adc_sck,
    output logic        o_adc_sdi,
    input  logic        i_adc_sdo,
    output logic        o_channel,
    output logic [15:0] o_data,
    output logic        o_valid
);

    localparam logic [15:0] CONVST_LAST = 16'(CONVST_CYCLES - 1);
    localparam logic [15:0] CONV_LAST   = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam bit          NO_GAP      = (GAP_CYCLES == 0);

    state_t              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                nextCh_q, prevCh_q, prevVld_q;
    logic [5:0]          sdiSr_q;
    logic                sdi_q;
    logic [SAMPLE_W-1:0] word_q;
    logic                channel_q, valid_q;
    logic [15:0]         data_q;
    logic [5:0]          cfgNext;
    logic                sck, riseStb, fallStb, shiftDone;

    assign cfgNext = cfgFor(nextCh_q);

    adc_sck_gen #(.SCK_HALF(SCK_HALF)) u_sckGen (
        .clk_i     (i_clk),
        .rstN_i    (i_rst_n),
        .run_i     (state_q == SHIFT),
        .sck_o     (sck),
        .riseStb_o (riseStb),
        .fallStb_o (fallStb),
        .done_o    (shiftDone)
    );

`ifdef ADC_SEQ_AVG_EN
    logic [13:0] acc_q [2];
    logic [1:0]  avgCnt_q [2];
    logic [13:0] accSum;

    // 4 x 12-bit always fits in 14 bits, so the sum never wraps
    assign accSum = acc_q[prevCh_q] + 14'(word_q);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (NO_GAP || cnt_q >= GAP_LAST) begin
                    if (i_enable) begin
                        state_d = CONVST;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CONVST: begin
                if (cnt_q == CONVST_LAST) begin
                    state_d = CONV_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CONV_WAIT: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHIFT: begin
                if (shiftDone) begin
                    state_d = PUBLISH;
                end
            end
            PUBLISH: begin
                cnt_d   = '0;
                state_d = (NO_GAP && i_enable) ? CONVST : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The shifted word belongs to the channel addressed one frame earlier (ADC pipeline)
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nextCh_q  <= 1'b0;
            prevCh_q  <= 1'b0;
            prevVld_q <= 1'b0;
            sdiSr_q   <= '0;
            sdi_q     <= 1'b0;
            word_q    <= '0;
            channel_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
            for (int i = 0; i < 2; i++) begin
                acc_q[i]    <= '0;
                avgCnt_q[i] <= '0;
            end
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;

            if (state_q == CONV_WAIT && state_d == SHIFT) begin
                sdi_q   <= cfgNext[5];
                sdiSr_q <= {cfgNext[4:0], 1'b0};
            end else if (state_q == SHIFT) begin
                if (fallStb) begin
                    sdi_q   <= sdiSr_q[5];
                    sdiSr_q <= {sdiSr_q[4:0], 1'b0};
                end
            end else begin
                sdi_q <= 1'b0;
            end

            if (riseStb) begin
                word_q <= {word_q[SAMPLE_W-2:0], i_adc_sdo};
            end

            if (state_q == PUBLISH) begin
`ifdef ADC_SEQ_AVG_EN
                if (prevVld_q) begin
                    if (avgCnt_q[prevCh_q] == 2'd3) begin
                        data_q               <= {accSum[13:2], 4'b0000};
                        channel_q            <= prevCh_q;
                        valid_q              <= 1'b1;
                        acc_q[prevCh_q]      <= '0;
                        avgCnt_q[prevCh_q]   <= '0;
                    end else begin
                        acc_q[prevCh_q]      <= accSum;
                        avgCnt_q[prevCh_q]   <= avgCnt_q[prevCh_q] + 2'd1;
                    end
                end
`else
                if (prevVld_q) begin
                    data_q    <= {word_q, 4'b0000};
                    channel_q <= prevCh_q;
                    valid_q   <= 1'b1;
                end
`endif
                prevCh_q  <= nextCh_q;
                prevVld_q <= 1'b1;
                nextCh_q  <= ~nextCh_q;
            end
        end
    end

    assign o_adc_convst = (state_q == CONVST);
    assign o_adc_sck    = sck;
    assign o_adc_sdi    = sdi_q;
    assign o_channel    = channel_q;
    assign o_data       = data_q;
    assign o_valid      = valid_q;

endmodule

// File: tb/tb_adc_joystick_seq.sv
// Directed bench for adc_joystick_seq with a pipelined LTC2308 behavioural model.
// Honours ADC_SEQ_AVG_EN to select the averaging scenarios.
module tb_adc_joystick_seq;

    localparam int SCK_HALF      = 4;
    localparam int CONVST_CYCLES = 2;
    localparam int CONV_CYCLES   = 80;
    localparam int GAP_CYCLES    = 16;
    localparam int FRAME = CONVST_CYCLES + CONV_CYCLES + 24 * SCK_HALF + 1 + GAP_CYCLES;
`ifdef ADC_SEQ_AVG_EN
    localparam int FIRST_VALID = 8 * FRAME;
`else
    localparam int FIRST_VALID = 2 * FRAME;
`endif
    localparam logic [5:0] CFG0 = 6'b100010;
    localparam logic [5:0] CFG1 = 6'b110010;

    logic        clk = 1'b0;
    logic        rstN;
    logic        enable;
    logic        adcConvst, adcSck, adcSdi, adcSdo;
    logic        channel, valid;
    logic [15:0] data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    adc_joystick_seq #(
        .SCK_HALF(SCK_HALF), .CONVST_CYCLES(CONVST_CYCLES),
        .CONV_CYCLES(CONV_CYCLES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_enable     (enable),
        .o_adc_convst (adcConvst),
        .o_adc_sck    (adcSck),
        .o_adc_sdi    (adcSdi),
        .i_adc_sdo    (adcSdo),
        .o_channel    (channel),
        .o_data       (data),
        .o_valid      (valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: a frame returns the sample for the channel configured in the previous frame
    logic [11:0] modelSample [2];
    logic [11:0] avgSeq [4];
    logic        useSeq;
    logic [11:0] sdoSr = '0;
    logic [11:0] rxSr = '0;
    logic [11:0] w = '0;
    int          rxCount = 0;
    int          seqIdx = 0;
    logic        hasCfg = 1'b0;
    logic        cfgCh = 1'b0;
    logic        prevConvst = 1'b0;
    logic        prevSck = 1'b0;

    assign adcSdo = sdoSr[11];

    always @(posedge clk) begin
        #1;
        if (!rstN) begin
            hasCfg  = 1'b0;
            rxCount = 0;
            seqIdx  = 0;
            sdoSr   = '0;
        end else begin
            if (adcConvst && !prevConvst) begin
                rxCount = 0;
                if (!hasCfg) begin
                    w = '0;
                end else if (cfgCh && useSeq && seqIdx < 4) begin
                    w = avgSeq[seqIdx];
                    seqIdx++;
                end else begin
                    w = modelSample[cfgCh];
                end
                sdoSr = w;
            end
            if (adcSck && !prevSck) begin
                rxSr = {rxSr[10:0], adcSdi};
                rxCount++;
                if (rxCount == 12) begin
                    cfgCh  = rxSr[10];
                    hasCfg = 1'b1;
                end
            end
            if (!adcSck && prevSck) begin
                sdoSr = {sdoSr[10:0], 1'b0};
            end
        end
        prevConvst = adcConvst;
        prevSck    = adcSck;
    end

    task automatic waitValid(input int budget, output int n, output bit got);
        n = 0;
        got = 1'b0;
        while (n < budget && !got) begin
            @(negedge clk);
            n++;
            if (valid) got = 1'b1;
        end
    endtask

    task automatic waitSckHigh();
        int guard = 0;
        while (!adcSck && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (adcConvst !== 1'b0) begin errors++; $display("[TB] FAIL reset_convst: got %b expected 0", adcConvst); end
        checks++; if (adcSck !== 1'b0) begin errors++; $display("[TB] FAIL reset_sck: got %b expected 0", adcSck); end
        checks++; if (adcSdi !== 1'b0) begin errors++; $display("[TB] FAIL reset_sdi: got %b expected 0", adcSdi); end
        checks++; if (channel !== 1'b0) begin errors++; $display("[TB] FAIL reset_channel: got %b expected 0", channel); end
        checks++; if (data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0000", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
        enable = 1'b1;
        rstN = 1'b1;
    endtask

    task automatic test_sequence();
        int n;
        bit got;
        int t0;
        waitValid(3 * FRAME, n, got);
        checks++; if (!got || n != FIRST_VALID) begin errors++; $display("[TB] FAIL first_latency: got %0d cycles (seen=%0d) expected %0d", n, got, FIRST_VALID); end
        checks++; if (channel !== 1'b0) begin errors++; $display("[TB] FAIL seq1_channel: got %b expected 0", channel); end
        checks++; if (data !== 16'hA5C0) begin errors++; $display("[TB] FAIL seq1_data: got %h expected A5C0", data); end
        t0 = cyc;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_pulse: got %b expected 0", valid); end
        repeat (FRAME / 2) @(negedge clk);
        checks++; if (data !== 16'hA5C0) begin errors++; $display("[TB] FAIL data_hold: got %h expected A5C0", data); end
        waitValid(2 * FRAME, n, got);
        checks++; if (!got || cyc - t0 != FRAME) begin errors++; $display("[TB] FAIL seq2_interval: got %0d expected %0d", cyc - t0, FRAME); end
        checks++; if (channel !== 1'b1) begin errors++; $display("[TB] FAIL seq2_channel: got %b expected 1", channel); end
        checks++; if (data !== 16'h3F00) begin errors++; $display("[TB] FAIL seq2_data: got %h expected 3F00", data); end
        t0 = cyc;
        waitValid(2 * FRAME, n, got);
        checks++; if (!got || cyc - t0 != FRAME) begin errors++; $display("[TB] FAIL seq3_interval: got %0d expected %0d", cyc - t0, FRAME); end
        checks++; if (channel !== 1'b0) begin errors++; $display("[TB] FAIL seq3_channel: got %b expected 0", channel); end
        checks++; if (data !== 16'hA5C0) begin errors++; $display("[TB] FAIL seq3_data: got %h expected A5C0", data); end
    endtask

    task automatic test_sdi_frames();
        logic [5:0] cfgSeen [2];
        for (int f = 0; f < 2; f++) begin
            int guard;
            int width;
            int lowCnt;
            int pulses;
            logic [11:0] bits;
            logic prev;
            guard = 0;
            while (adcConvst && guard < 2 * FRAME) begin @(negedge clk); guard++; end
            guard = 0;
            while (!adcConvst && guard < 2 * FRAME) begin @(negedge clk); guard++; end
            width = 0;
            while (adcConvst && width < FRAME) begin width++; @(negedge clk); end
            lowCnt = 0;
            while (!adcSck && lowCnt < FRAME) begin lowCnt++; @(negedge clk); end
            pulses = 0;
            bits = '0;
            prev = 1'b0;
            for (int i = 0; i < 24 * SCK_HALF + 4; i++) begin
                if (adcSck && !prev) begin
                    pulses++;
                    bits = {bits[10:0], adcSdi};
                end
                prev = adcSck;
                @(negedge clk);
            end
            checks++; if (width != CONVST_CYCLES) begin errors++; $display("[TB] FAIL convst_width: got %0d expected %0d", width, CONVST_CYCLES); end
            checks++; if (lowCnt != CONV_CYCLES + SCK_HALF) begin errors++; $display("[TB] FAIL conv_wait: got %0d expected %0d", lowCnt, CONV_CYCLES + SCK_HALF); end
            checks++; if (pulses != 12) begin errors++; $display("[TB] FAIL sck_pulses: got %0d expected 12", pulses); end
            checks++; if (bits[5:0] !== 6'b000000) begin errors++; $display("[TB] FAIL sdi_tail: got %b expected 000000", bits[5:0]); end
            cfgSeen[f] = bits[11:6];
        end
        checks++;
        if (!((cfgSeen[0] === CFG0 && cfgSeen[1] === CFG1) || (cfgSeen[0] === CFG1 && cfgSeen[1] === CFG0))) begin
            errors++;
            $display("[TB] FAIL sdi_cfg_pair: got %b,%b expected %b/%b alternating", cfgSeen[0], cfgSeen[1], CFG0, CFG1);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        bit got;
        int convstSeen;
        int validSeen;
        logic expCh;
        waitSckHigh();
        enable = 1'b0;
        waitValid(FRAME, n, got);
        checks++; if (!got) begin errors++; $display("[TB] FAIL drop_valid: got none expected one within %0d", FRAME); end
        expCh = ~channel;
        convstSeen = 0;
        validSeen = 0;
        repeat (5 * FRAME) begin
            @(negedge clk);
            if (adcConvst) convstSeen++;
            if (valid) validSeen++;
        end
        checks++; if (convstSeen != 0) begin errors++; $display("[TB] FAIL drop_convst: got %0d expected 0", convstSeen); end
        checks++; if (validSeen != 0) begin errors++; $display("[TB] FAIL drop_extra_valid: got %0d expected 0", validSeen); end
        enable = 1'b1;
        waitValid(FRAME, n, got);
        checks++; if (!got) begin errors++; $display("[TB] FAIL resume_valid: got none expected one within %0d", FRAME); end
        checks++; if (channel !== expCh) begin errors++; $display("[TB] FAIL resume_channel: got %b expected %b", channel, expCh); end
        checks++; if (data !== (expCh ? 16'h3F00 : 16'hA5C0)) begin errors++; $display("[TB] FAIL resume_data: got %h expected %h", data, expCh ? 16'h3F00 : 16'hA5C0); end
    endtask

    task automatic test_boundary();
        int n;
        bit got;
        logic expCh;
        modelSample[0] = 12'hFFF;
        modelSample[1] = 12'h000;
        waitValid(2 * FRAME, n, got);
        expCh = ~channel;
        for (int k = 0; k < 2; k++) begin
            waitValid(2 * FRAME, n, got);
            checks++; if (!got || channel !== expCh) begin errors++; $display("[TB] FAIL boundary_channel: got %b expected %b", channel, expCh); end
            checks++; if (data !== (expCh ? 16'h0000 : 16'hFFF0)) begin errors++; $display("[TB] FAIL boundary_data: got %h expected %h", data, expCh ? 16'h0000 : 16'hFFF0); end
            expCh = ~expCh;
        end
        modelSample[0] = 12'hA5C;
        modelSample[1] = 12'h3F0;
    endtask

    task automatic test_reset_mid_shift();
        int n;
        bit got;
        waitSckHigh();
        rstN = 1'b0;
        @(negedge clk);
        checks++; if (adcSck !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sck: got %b expected 0", adcSck); end
        checks++; if (adcConvst !== 1'b0) begin errors++; $display("[TB] FAIL midrst_convst: got %b expected 0", adcConvst); end
        checks++; if (data !== 16'h0000) begin errors++; $display("[TB] FAIL midrst_data: got %h expected 0000", data); end
        checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid: got %b expected 0", valid); end
        rstN = 1'b1;
        waitValid(FIRST_VALID + FRAME, n, got);
        checks++; if (!got || n != FIRST_VALID) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected %0d", n, FIRST_VALID); end
        checks++; if (channel !== 1'b0) begin errors++; $display("[TB] FAIL midrst_channel: got %b expected 0", channel); end
        checks++; if (data !== 16'hA5C0) begin errors++; $display("[TB] FAIL midrst_data_after: got %h expected A5C0", data); end
    endtask

`ifdef ADC_SEQ_AVG_EN
    task automatic test_avg();
        int ch0Count = 0;
        int ch1Count = 0;
        logic [15:0] ch0Data = '0;
        logic [15:0] ch1Data = '0;
        useSeq = 1'b1;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        repeat (9 * FRAME + 20) begin
            @(negedge clk);
            if (valid && channel) begin ch1Count++; ch1Data = data; end
            if (valid && !channel) begin ch0Count++; ch0Data = data; end
        end
        checks++; if (ch1Count != 1) begin errors++; $display("[TB] FAIL avg_ch1_count: got %0d expected 1", ch1Count); end
        checks++; if (ch1Data !== {12'd102, 4'b0000}) begin errors++; $display("[TB] FAIL avg_ch1_data: got %h expected %h", ch1Data, {12'd102, 4'b0000}); end
        checks++; if (ch0Count != 1) begin errors++; $display("[TB] FAIL avg_ch0_count: got %0d expected 1", ch0Count); end
        checks++; if (ch0Data !== 16'hA5C0) begin errors++; $display("[TB] FAIL avg_ch0_data: got %h expected A5C0", ch0Data); end
        useSeq = 1'b0;
    endtask

    task automatic test_avg_boundary();
        int n;
        bit got;
        modelSample[0] = 12'hFFF;
        modelSample[1] = 12'hFFF;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        waitValid(FIRST_VALID + FRAME, n, got);
        checks++; if (!got || channel !== 1'b0) begin errors++; $display("[TB] FAIL avgmax_channel: got %b expected 0", channel); end
        checks++; if (data !== 16'hFFF0) begin errors++; $display("[TB] FAIL avgmax_data: got %h expected FFF0", data); end
        modelSample[0] = 12'hA5C;
        modelSample[1] = 12'h3F0;
    endtask
`endif

    initial begin
        #(80 * FRAME * 10);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelSample[0] = 12'hA5C;
        modelSample[1] = 12'h3F0;
        avgSeq[0] = 12'd100;
        avgSeq[1] = 12'd101;
        avgSeq[2] = 12'd102;
        avgSeq[3] = 12'd105;
        useSeq = 1'b0;
        rstN = 1'b0;
        enable = 1'b0;
        test_reset();
`ifdef ADC_SEQ_AVG_EN
        test_sdi_frames();
        test_avg();
        test_avg_boundary();
`else
        test_sequence();
        test_sdi_frames();
        test_enable_drop();
        test_boundary();
`endif
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
